fc_neuron_acc: RTL and testbench

Sequential accumulation stage that sits directly downstream of the fixed-point ALU in the fully connected datapath.
- Consumes a stream of signed fixed-point products, one per beat.
- Sums them in a widened accumulator, adds a per-neuron bias, then saturates to DATA_WIDTH.
- Optionally applies ReLU and presents one neuron result on a valid/ready output.
- One neuron per start command; the upstream controller sequences start pulses per neuron.

---
 rtl/fc_pkg.sv | 29 ++
 rtl/fc_neuron_acc_if.sv | 30 +++
 rtl/fxp_sat_relu.sv | 35 +++
 rtl/fc_neuron_acc.sv | 98 +++++++++
 tb/tb_fc_neuron_acc.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected accumulation datapath.
// Holds the Q-format constants, derived widths, saturation bounds, the
// neuron accumulator state enum and a sign-extension helper.
package fc_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRACTIONAL = 5;
    localparam int unsigned MAX_INPUTS = 1024;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_INPUTS + 1);
    // Headroom for MAX_INPUTS full-scale products plus the bias.
    localparam int unsigned ACC_WIDTH  = DATA_WIDTH + $clog2(MAX_INPUTS) + 1;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    // Fixed-point 1.0 in the shared Q format.
    localparam logic [DATA_WIDTH-1:0] Q_ONE   = DATA_WIDTH'(1) << FRACTIONAL;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StBias,
        StOut
    } fc_state_e;

    function automatic logic [ACC_WIDTH-1:0] sext_data(input logic [DATA_WIDTH-1:0] d);
        return {{(ACC_WIDTH - DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
    endfunction

endpackage

// File: rtl/fc_neuron_acc_if.sv
// Command, product-stream and result handshake bundle for fc_neuron_acc.
//   master: controller/producer side (drives start, operands, beats, out_ready)
//   slave : accumulator side (drives in_ready, out_valid, out_data, sat, busy)
interface fc_neuron_acc_if;
    import fc_pkg::*;

    logic                  start;
    logic [CNT_WIDTH-1:0]  num_inputs;
    logic [DATA_WIDTH-1:0] bias;
    logic                  relu_en;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  sat;
    logic                  busy;

    modport master (
        output start, num_inputs, bias, relu_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sat, busy
    );

    modport slave (
        input  start, num_inputs, bias, relu_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sat, busy
    );

endinterface

// File: rtl/fxp_sat_relu.sv
// Combinational clip of a wide accumulator value to DATA_WIDTH with optional ReLU.
//   acc     : ACC_WIDTH two's complement value
//   relu_en : force negative clipped results to zero
//   res     : DATA_WIDTH result
//   sat     : set when acc was outside the DATA_WIDTH range (independent of ReLU)
module fxp_sat_relu
    import fc_pkg::*;
(
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic                  relu_en,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  sat
);

    // The value fits iff every bit from the result sign bit upward agrees.
    logic [ACC_WIDTH-DATA_WIDTH:0] top_bits;
    logic                          ovf;
    logic [DATA_WIDTH-1:0]         clipped;

    assign top_bits = acc[ACC_WIDTH-1:DATA_WIDTH-1];
    assign ovf      = !((&top_bits) || !(|top_bits));

    always_comb begin
        clipped = acc[DATA_WIDTH-1:0];
        if (ovf) begin
            clipped = acc[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
        res = clipped;
        if (relu_en && clipped[DATA_WIDTH-1]) begin
            res = '0;
        end
        sat = ovf;
    end

endmodule

// File: rtl/fc_neuron_acc.sv
// Neuron accumulation stage: sums a stream of signed products, adds a bias,
// saturates to DATA_WIDTH, optionally applies ReLU and presents the result on a
// valid/ready output. One neuron per start command.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fc_neuron_acc_if.slave (start/num_inputs/bias/relu_en command,
//         in_valid/in_ready/in_data beats, out_valid/out_ready/out_data/sat
//         result, busy status)
module fc_neuron_acc
    import fc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fc_neuron_acc_if.slave bus
);

    fc_state_e             state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [DATA_WIDTH-1:0] bias_q;
    logic                  relu_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  sat_q;
    logic [DATA_WIDTH-1:0] clip_data;
    logic                  clip_sat;

    assign cnt_next = cnt_q + CNT_WIDTH'(1);

    fxp_sat_relu u_sat_relu (
        .acc     (acc_q),
        .relu_en (relu_q),
        .res     (clip_data),
        .sat     (clip_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            num_q       <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        num_q   <= bus.num_inputs;
                        bias_q  <= bus.bias;
                        relu_q  <= bus.relu_en;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= (bus.num_inputs != '0) ? StAcc : StBias;
                    end
                end
                StAcc: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_q + sext_data(bus.in_data);
                        cnt_q <= cnt_next;
                        if (cnt_next == num_q) begin
                            state_q <= StBias;
                        end
                    end
                end
                StBias: begin
                    acc_q   <= acc_q + sext_data(bias_q);
                    state_q <= StOut;
                end
                StOut: begin
                    // First OUT cycle registers the clipped sum; the result is
                    // then held until the downstream handshake.
                    if (!out_valid_q) begin
                        out_data_q  <= clip_data;
                        sat_q       <= clip_sat;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StAcc);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fc_neuron_acc.sv
module tb_fc_neuron_acc;
    import fc_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fc_neuron_acc_if bus ();

    fc_neuron_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [DATA_WIDTH-1:0] beats[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, add bias, clamp to the signed 16-bit range,
    // then ReLU on the clamped value.
    function automatic void model(input int n, input logic [15:0] b, input logic relu,
                                  output logic [15:0] d, output logic s);
        longint sum;
        sum = 0;
        for (int i = 0; i < n; i++) sum += longint'($signed(beats[i]));
        sum += longint'($signed(b));
        if (sum > 32767) begin
            d = 16'h7FFF;
            s = 1'b1;
        end else if (sum < -32768) begin
            d = 16'h8000;
            s = 1'b1;
        end else begin
            d = 16'(sum);
            s = 1'b0;
        end
        if (relu && d[15]) d = 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (bus.start && !bus.busy) begin
            assert (bus.num_inputs <= CNT_WIDTH'(MAX_INPUTS))
            else $error("num_inputs above MAX_INPUTS");
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // gaps: 0 continuous valid, 1 alternating, 2 random. hold: cycles of out_ready low.
    task automatic run_case(input string tag, input int n, input logic [15:0] b,
                            input logic relu, input int gaps, input int hold);
        logic [15:0] exp_d;
        logic        exp_s;
        int          e;
        int          idx;
        int          guard;
        bit          rdy;
        bit          any_rdy;
        model(n, b, relu, exp_d, exp_s);

        bus.start      = 1'b1;
        bus.num_inputs = CNT_WIDTH'(n);
        bus.bias       = b;
        bus.relu_en    = relu;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq({tag, ":busy_run"}, 32'(bus.busy), 32'd1);

        e       = 0;
        idx     = 0;
        guard   = 0;
        any_rdy = 1'b0;
        while (idx < n && guard < 5000) begin
            if (gaps == 0)      bus.in_valid = 1'b1;
            else if (gaps == 1) bus.in_valid = (guard % 2 == 0);
            else                bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = beats[idx];
            rdy         = bus.in_ready;
            any_rdy    |= rdy;
            if (guard < 8) check_eq({tag, ":in_ready_acc"}, 32'(rdy), 32'd1);
            @(posedge clk);
            e++;
            if (rdy && bus.in_valid) idx++;
            @(negedge clk);
            guard++;
        end
        if (idx < n) check_eq({tag, ":beat_timeout"}, 32'(idx), 32'(n));

        // Stray beats while not in ACC must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
        guard        = 0;
        while (!bus.out_valid && guard < 20) begin
            any_rdy |= bus.in_ready;
            check_eq({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            e++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        check_eq({tag, ":out_valid"}, 32'(bus.out_valid), 32'd1);
        if (gaps == 0) check_eq({tag, ":latency"}, 32'(e), 32'(n + 2));
        if (n == 0) check_eq({tag, ":no_ready_n0"}, 32'(any_rdy), 32'd0);
        check_eq({tag, ":data"}, 32'(bus.out_data), 32'(exp_d));
        check_eq({tag, ":sat"}, 32'(bus.sat), 32'(exp_s));

        // Start during OUT (including the handshake cycle) must be ignored.
        bus.start      = 1'b1;
        bus.num_inputs = CNT_WIDTH'(1);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, ":hold_data"}, 32'(bus.out_data), 32'(exp_d));
            check_eq({tag, ":hold_sat"}, 32'(bus.sat), 32'(exp_s));
            check_eq({tag, ":hold_busy"}, 32'(bus.busy), 32'd1);
            check_eq({tag, ":hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, ":hs_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, ":hs_busy"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check_eq({tag, ":idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.num_inputs = '0;
        bus.bias       = '0;
        bus.relu_en    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        #13;
        check_eq("rst:busy", 32'(bus.busy), 32'd0);
        check_eq("rst:in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst:out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst:out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst:sat", 32'(bus.sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        beats = '{16'h0020, 16'h0040, 16'hFFF0};
        run_case("basic", 3, 16'h0010, 1'b0, 0, 0);

        beats = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        run_case("sat_pos", 4, 16'h0000, 1'b0, 0, 0);
        beats = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
        run_case("sat_neg", 4, 16'h0000, 1'b0, 0, 0);

        beats = '{16'hFFC0, 16'h0020};
        run_case("relu_on", 2, 16'h0000, 1'b1, 0, 0);
        run_case("relu_off", 2, 16'h0000, 1'b0, 0, 0);

        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back(16'($urandom_range(0, 16'h0FFF)));
        run_case("backpr", 6, 16'hFF00, 1'b0, 1, 5);

        beats.delete();
        run_case("n_zero", 0, 16'hFFE0, 1'b0, 0, 0);

        // Abort mid-accumulation with an asynchronous reset.
        bus.start      = 1'b1;
        bus.num_inputs = CNT_WIDTH'(4);
        bus.bias       = 16'h0100;
        bus.relu_en    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h1234;
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("abort:busy", 32'(bus.busy), 32'd0);
        check_eq("abort:in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("abort:out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort:out_data", 32'(bus.out_data), 32'd0);
        check_eq("abort:sat", 32'(bus.sat), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beats = '{16'h0020};
        run_case("after_rst", 1, 16'h0000, 1'b0, 0, 0);

        // Largest legal neuron at the most negative corner.
        beats.delete();
        for (int i = 0; i < MAX_INPUTS; i++) beats.push_back(16'h8000);
        run_case("max_n", MAX_INPUTS, 16'h8000, 1'b0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            n = $urandom_range(0, 12);
            beats.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) beats.push_back(16'($urandom_range(0, 1) ? 16'h7F00 : 16'h8100));
                else beats.push_back(16'($urandom));
            end
            run_case("rand", n, 16'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        end

        check_eq("q_one", 32'(Q_ONE), 32'(beats.size() >= 0 ? 16'h0020 : 16'h0000));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
